mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle sequencing controller for the RV32I core. A Moore/Mealy FSM steps one instruction at a time through fetch, decode, execute, memory and writeback, driving the mux selects and write enables of the shared datapath. The datapath is the PC/IR/old-PC registers, register file, immediate generator, ALU and a single unified memory port. It also sequences the single-cycle memory handshake, detects illegal opcodes and memory timeouts, and halts the core in a sticky trap state.

## Interface
- TIMEOUT_CYCLES, 255: consecutive wait cycles with `mem_ready` low in any memory state before trapping; range 1..1023.
- clk  input  1  core clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- opcode  input  `OPCODE_WIDTH` (7)  IR[6:0], valid from S_DECODE onward
- funct3  input  `FUNCT3_WIDTH` (3)  IR[14:12]
- branch_taken  input  1  ALU compare result, valid in S_BRANCH
- mem_ready  input  1  memory completes the current request this cycle
- mem_req  output  1  memory request, held until `mem_ready`
- mem_we  output  1  1 = store
- iord  output  1  address select: 0 = PC, 1 = ALU-out register
- ir_write  output  1  load IR (datapath latches old_pc with it)
- mdr_write  output  1  load memory-data register
- pc_write  output  1  update PC
- pc_sel  output  2  0 = PC+4, 1 = old_pc+imm, 2 = (rs1+imm)&~1
- reg_write  output  1  register-file write enable
- wb_sel  output  2  0 = ALU-out, 1 = MDR, 2 = old_pc+4
- alu_src_a  output  2  0 = rs1, 1 = old_pc, 2 = zero
- alu_src_b  output  2  0 = rs2, 1 = imm
- alu_op  output  2  0 = add, 1 = funct-decoded, 2 = branch compare
- instr_done  output  1  one-cycle retire pulse
- halt  output  1  sticky trap indicator
- trap_cause  output  2  0 = none, 1 = illegal opcode, 2 = memory timeout
- state  output  4  current state encoding, for debug

## Operation
- State encodings:
  - 0 S_RESET
  - 1 S_FETCH
  - 2 S_DECODE
  - 3 S_EXEC
  - 4 S_ALUWB
  - 5 S_MEMADDR
  - 6 S_MEMRD
  - 7 S_LOADWB
  - 8 S_MEMWR
  - 9 S_BRANCH
  - 10 S_JUMP
  - 11 S_TRAP
- Any output not listed for a state is 0.
- S_RESET: all outputs 0. Next state is S_FETCH.
- S_FETCH: mem_req=1, iord=0. On mem_ready: ir_write=1, pc_write=1, pc_sel=0, then S_DECODE. Otherwise stay.
- S_DECODE: no enables asserted. Next state by opcode:
  - 0000011 (load) and 0100011 (store): S_MEMADDR
  - 0110011, 0010011, 0110111, 0010111: S_EXEC
  - 1100011: S_BRANCH
  - 1101111, and 1100111 with funct3=000: S_JUMP
  - anything else: S_TRAP with trap_cause=1
- S_EXEC operand selects:
  - OP: src_a=0, src_b=0, alu_op=1
  - OP-IMM: src_a=0, src_b=1, alu_op=1
  - LUI: src_a=2, src_b=1, alu_op=0
  - AUIPC: src_a=1, src_b=1, alu_op=0
  - Next state is S_ALUWB.
- S_ALUWB: reg_write=1, wb_sel=0, instr_done=1. Next state is S_FETCH.
- S_MEMADDR: src_a=0, src_b=1, alu_op=0. Next state is S_MEMRD for a load, S_MEMWR for a store.
- S_MEMRD: mem_req=1, iord=1. On mem_ready: mdr_write=1, then S_LOADWB.
- S_LOADWB: reg_write=1, wb_sel=1, instr_done=1. Next state is S_FETCH.
- S_MEMWR: mem_req=1, iord=1, mem_we=1. On mem_ready: instr_done=1, then S_FETCH.
- S_BRANCH: src_a=0, src_b=0, alu_op=2, instr_done=1. If branch_taken: pc_write=1, pc_sel=1. Next state is S_FETCH.
- S_JUMP: reg_write=1, wb_sel=2, pc_write=1, instr_done=1. pc_sel=1 for JAL, 2 for JALR. Next state is S_FETCH.
- S_TRAP: halt=1, trap_cause held. Stays in S_TRAP until reset; opcode and mem_ready are ignored.
- Timeout counter:
  - 10-bit counter, cleared on every state change.
  - Increments each cycle spent in S_FETCH, S_MEMRD or S_MEMWR with mem_ready=0.
  - When the count equals TIMEOUT_CYCLES with mem_ready still 0: next state is S_TRAP, trap_cause=2.
  - mem_ready=1 in that same cycle wins over timeout.
- Register write to x0 is allowed; the register file ignores it.

## Timing
- state, the timeout counter and trap_cause are registered.
- Outputs are decoded combinationally from state. ir_write, mdr_write, S_FETCH pc_write, S_MEMWR instr_done and S_BRANCH pc_write are qualified combinationally by mem_ready or branch_taken.
- While mem_req=1: iord and mem_we stay stable until the cycle mem_ready=1. mem_req drops the following cycle.
- Reset assertion:
  - Takes effect immediately: state=S_RESET, counter=0, trap_cause=0, all outputs 0.
  - Any in-flight request is abandoned without waiting.
- After reset deassertion: one cycle in S_RESET, then S_FETCH.
- Zero-wait cycle counts (mem_ready=1 on request):
  - R, I, LUI, AUIPC: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL/JALR: 3
- Each memory wait cycle adds 1.

## Test plan
- Reset: hold rst=0 for 3 cycles mid-S_MEMRD with mem_req=1 -> mem_req drops immediately, all outputs 0. Release rst -> state 0 for one cycle, then 1.
- R-type 0110011 with zero-wait memory -> states 1,2,3,4. reg_write pulses at cycle 4 with wb_sel=0, instr_done=1. Next cycle state=1.
- Load 0000011 with mem_ready delayed 2 cycles on both fetch and data -> 9 cycles total. mdr_write is exactly one pulse. reg_write with wb_sel=1.
- Branch 1100011, first with branch_taken=1 then with 0 -> first: pc_write=1, pc_sel=1 in S_BRANCH. Second: pc_write=0. Both retire in 3 cycles.
- Illegal opcode 1111111 -> S_DECODE goes to state 11: halt=1, trap_cause=1. State holds for 20 cycles despite toggling mem_ready.
- TIMEOUT_CYCLES=4 with mem_ready stuck 0 in S_FETCH -> trap_cause=2, halt=1 after exactly 4 wait cycles. Repeat with mem_ready=1 on the 4th cycle -> no trap, state=2.

Source files
------------

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Brief    : Multi-cycle RV32I sequencing FSM with memory-timeout and
//            illegal-opcode trap handling.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       halt,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  localparam logic [3:0] S_RESET   = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EXEC    = 4'd3;
  localparam logic [3:0] S_ALUWB   = 4'd4;
  localparam logic [3:0] S_MEMADDR = 4'd5;
  localparam logic [3:0] S_MEMRD   = 4'd6;
  localparam logic [3:0] S_LOADWB  = 4'd7;
  localparam logic [3:0] S_MEMWR   = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_JUMP    = 4'd10;
  localparam logic [3:0] S_TRAP    = 4'd11;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_op     = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;

  localparam logic [1:0] c_cause_illegal = 2'd1;
  localparam logic [1:0] c_cause_timeout = 2'd2;
  localparam logic [9:0] c_timeout       = 10'(TIMEOUT_CYCLES);

  logic [3:0] r_state;
  logic [9:0] r_cnt;
  logic [1:0] r_cause;
  logic [3:0] w_next;
  logic [1:0] w_next_cause;
  logic [9:0] w_cnt_inc;
  logic       w_waiting;
  logic       w_timeout;

  assign w_cnt_inc = r_cnt + 10'd1;
  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                     && !mem_ready;
  // The wait cycle being spent right now counts toward the limit.
  assign w_timeout = w_waiting && (w_cnt_inc == c_timeout);

  always_comb begin
    w_next       = r_state;
    w_next_cause = r_cause;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_ready) begin
          if (r_state == S_FETCH)      w_next = S_DECODE;
          else if (r_state == S_MEMRD) w_next = S_LOADWB;
          else                         w_next = S_FETCH;
        end else if (w_timeout) begin
          w_next       = S_TRAP;
          w_next_cause = c_cause_timeout;
        end
      end
      S_DECODE: begin
        case (opcode)
          c_op_load, c_op_store:                    w_next = S_MEMADDR;
          c_op_op, c_op_imm, c_op_lui, c_op_auipc:  w_next = S_EXEC;
          c_op_branch:                              w_next = S_BRANCH;
          c_op_jal:                                 w_next = S_JUMP;
          default: begin
            if ((opcode == c_op_jalr) && (funct3 == 3'b000)) begin
              w_next = S_JUMP;
            end else begin
              w_next       = S_TRAP;
              w_next_cause = c_cause_illegal;
            end
          end
        endcase
      end
      S_EXEC:    w_next = S_ALUWB;
      S_MEMADDR: w_next = (opcode == c_op_store) ? S_MEMWR : S_MEMRD;
      S_ALUWB, S_LOADWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
      S_TRAP:    w_next = S_TRAP;
      default:   w_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RESET;
      r_cnt   <= 10'd0;
      r_cause <= 2'd0;
    end else begin
      r_state <= w_next;
      r_cause <= w_next_cause;
      if (w_next != r_state) r_cnt <= 10'd0;
      else if (w_waiting)    r_cnt <= w_cnt_inc;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 2'd0;
    reg_write  = 1'b0;
    wb_sel     = 2'd0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    instr_done = 1'b0;
    halt       = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        case (opcode)
          c_op_op:    alu_op = 2'd1;
          c_op_imm:   begin alu_src_b = 2'd1; alu_op = 2'd1; end
          c_op_lui:   begin alu_src_a = 2'd2; alu_src_b = 2'd1; end
          c_op_auipc: begin alu_src_a = 2'd1; alu_src_b = 2'd1; end
          default:    ;
        endcase
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMADDR: alu_src_b = 2'd1;
      S_MEMRD: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mdr_write = mem_ready;
      end
      S_LOADWB: begin
        reg_write  = 1'b1;
        wb_sel     = 2'd1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        mem_we     = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        alu_op     = 2'd2;
        instr_done = 1'b1;
        pc_write   = branch_taken;
        pc_sel     = branch_taken ? 2'd1 : 2'd0;
      end
      S_JUMP: begin
        reg_write  = 1'b1;
        wb_sel     = 2'd2;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        pc_sel     = (opcode == c_op_jal) ? 2'd1 : 2'd2;
      end
      S_TRAP:  halt = 1'b1;
      default: ;
    endcase
  end

  assign trap_cause = r_cause;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control
// Brief    : Self-checking bench for mc_control: vector table, corner-case
//            sequences and randomized instructions against a trace model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, mdr_write, pc_write;
  logic [1:0] pc_sel;
  logic       reg_write;
  logic [1:0] wb_sel, alu_src_a, alu_src_b, alu_op;
  logic       instr_done, halt;
  logic [1:0] trap_cause;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_control #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .mdr_write(mdr_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
    .halt(halt), .trap_cause(trap_cause), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_we, iord, ir_write, mdr_write, pc_write;
    logic [1:0] pc_sel;
    logic       reg_write;
    logic [1:0] wb_sel, src_a, src_b, alu_op;
    logic       instr_done, halt;
    logic [1:0] cause;
  } outs_t;

  typedef struct {
    outs_t o;
    logic  rdy;
    logic  rdy_any;
  } cyc_t;

  typedef struct {
    string      name;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       taken;
    int         fwait;
    int         dwait;
    int         cycles;   // cycles up to retire pulse or first halt cycle
    logic [1:0] cause;
  } vec_t;

  cyc_t  exp_q[$];
  vec_t  tbl[18];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic outs_t sample();
    outs_t o;
    o.st = state; o.mem_req = mem_req; o.mem_we = mem_we; o.iord = iord;
    o.ir_write = ir_write; o.mdr_write = mdr_write; o.pc_write = pc_write;
    o.pc_sel = pc_sel; o.reg_write = reg_write; o.wb_sel = wb_sel;
    o.src_a = alu_src_a; o.src_b = alu_src_b; o.alu_op = alu_op;
    o.instr_done = instr_done; o.halt = halt; o.cause = trap_cause;
    return o;
  endfunction

  task automatic check(input string nm, input outs_t got, input outs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic outs_t blank(input logic [3:0] st);
    outs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  // 0 illegal, 1 OP, 2 OP-IMM, 3 LUI, 4 AUIPC, 5 load, 6 store, 7 branch, 8 JAL, 9 JALR
  function automatic int classify(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0110011: return 1;
      7'b0010011: return 2;
      7'b0110111: return 3;
      7'b0010111: return 4;
      7'b0000011: return 5;
      7'b0100011: return 6;
      7'b1100011: return 7;
      7'b1101111: return 8;
      7'b1100111: return (f3 == 3'd0) ? 9 : 0;
      default:    return 0;
    endcase
  endfunction

  task automatic push(input outs_t o, input logic rdy, input logic any);
    cyc_t c;
    c.o = o; c.rdy = rdy; c.rdy_any = any;
    exp_q.push_back(c);
  endtask

  // A trap is sticky: expect it to hold for 20 cycles whatever mem_ready does.
  task automatic push_trap(input logic [1:0] cause);
    outs_t o;
    o = blank(4'd11);
    o.halt = 1'b1;
    o.cause = cause;
    for (int i = 0; i < 20; i++) push(o, 1'b0, 1'b1);
  endtask

  task automatic mem_phase(input logic [3:0] st, input int waits, output logic tr);
    outs_t o;
    int    n;
    o = blank(st);
    o.mem_req = 1'b1;
    o.iord    = (st != 4'd1);
    o.mem_we  = (st == 4'd8);
    n = (waits >= TO) ? TO : waits;
    for (int i = 0; i < n; i++) push(o, 1'b0, 1'b0);
    if (waits >= TO) begin
      push_trap(2'd2);
      tr = 1'b1;
    end else begin
      if (st == 4'd1) begin o.ir_write = 1'b1; o.pc_write = 1'b1; end
      else if (st == 4'd6) o.mdr_write = 1'b1;
      else o.instr_done = 1'b1;
      push(o, 1'b1, 1'b0);
      tr = 1'b0;
    end
  endtask

  task automatic build(input vec_t v, output logic trapped);
    outs_t o;
    logic  tr;
    int    cls;
    exp_q.delete();
    trapped = 1'b0;
    mem_phase(4'd1, v.fwait, tr);
    if (tr) begin trapped = 1'b1; return; end
    push(blank(4'd2), 1'b0, 1'b1);
    cls = classify(v.opc, v.f3);
    case (cls)
      1, 2, 3, 4: begin
        o = blank(4'd3);
        if (cls == 1) o.alu_op = 2'd1;
        if (cls == 2) begin o.src_b = 2'd1; o.alu_op = 2'd1; end
        if (cls == 3) begin o.src_a = 2'd2; o.src_b = 2'd1; end
        if (cls == 4) begin o.src_a = 2'd1; o.src_b = 2'd1; end
        push(o, 1'b0, 1'b1);
        o = blank(4'd4);
        o.reg_write = 1'b1; o.instr_done = 1'b1;
        push(o, 1'b0, 1'b1);
      end
      5, 6: begin
        o = blank(4'd5);
        o.src_b = 2'd1;
        push(o, 1'b0, 1'b1);
        mem_phase((cls == 5) ? 4'd6 : 4'd8, v.dwait, tr);
        trapped = tr;
        if (!tr && cls == 5) begin
          o = blank(4'd7);
          o.reg_write = 1'b1; o.wb_sel = 2'd1; o.instr_done = 1'b1;
          push(o, 1'b0, 1'b1);
        end
      end
      7: begin
        o = blank(4'd9);
        o.alu_op = 2'd2; o.instr_done = 1'b1;
        o.pc_write = v.taken;
        o.pc_sel = v.taken ? 2'd1 : 2'd0;
        push(o, 1'b0, 1'b1);
      end
      8, 9: begin
        o = blank(4'd10);
        o.reg_write = 1'b1; o.wb_sel = 2'd2; o.pc_write = 1'b1; o.instr_done = 1'b1;
        o.pc_sel = (cls == 8) ? 2'd1 : 2'd2;
        push(o, 1'b0, 1'b1);
      end
      default: begin
        push_trap(2'd1);
        trapped = 1'b1;
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1 check("reset_assert", sample(), '0);
    repeat (2) begin
      @(negedge clk);
      #1 check("reset_hold", sample(), '0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1 check("reset_release", sample(), '0);
  endtask

  task automatic play(input vec_t v);
    logic  tr;
    int    seen;
    outs_t got;
    seen = 0;
    build(v, tr);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      opcode = v.opc;
      funct3 = v.f3;
      branch_taken = v.taken;
      mem_ready = exp_q[i].rdy_any ? 1'($urandom_range(0, 1)) : exp_q[i].rdy;
      #1;
      got = sample();
      if (seen == 0 && (got.instr_done || got.halt)) seen = i + 1;
      check($sformatf("%s c%0d", v.name, i), got, exp_q[i].o);
    end
    if (v.cycles > 0) begin
      n_cmp++;
      if (seen != v.cycles || got.cause !== v.cause) begin
        n_bad++;
        $display("FAIL %s latency: got %0d cycles cause %0d, want %0d cycles cause %0d",
                 v.name, seen, got.cause, v.cycles, v.cause);
      end
    end
    if (tr) do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    vec_t  v;
    outs_t o;
    int    r;
    logic [6:0] legal [10];

    tbl[0]  = '{"r_type",      7'b0110011, 3'd0, 1'b0, 0, 0, 4, 2'd0};
    tbl[1]  = '{"op_imm",      7'b0010011, 3'd5, 1'b0, 0, 0, 4, 2'd0};
    tbl[2]  = '{"lui",         7'b0110111, 3'd2, 1'b0, 0, 0, 4, 2'd0};
    tbl[3]  = '{"auipc",       7'b0010111, 3'd7, 1'b0, 0, 0, 4, 2'd0};
    tbl[4]  = '{"load",        7'b0000011, 3'd2, 1'b0, 0, 0, 5, 2'd0};
    tbl[5]  = '{"load_w2w2",   7'b0000011, 3'd2, 1'b0, 2, 2, 9, 2'd0};
    tbl[6]  = '{"store",       7'b0100011, 3'd2, 1'b0, 0, 0, 4, 2'd0};
    tbl[7]  = '{"store_w1w3",  7'b0100011, 3'd0, 1'b0, 1, 3, 8, 2'd0};
    tbl[8]  = '{"br_taken",    7'b1100011, 3'd0, 1'b1, 0, 0, 3, 2'd0};
    tbl[9]  = '{"br_not",      7'b1100011, 3'd1, 1'b0, 0, 0, 3, 2'd0};
    tbl[10] = '{"jal",         7'b1101111, 3'd3, 1'b0, 0, 0, 3, 2'd0};
    tbl[11] = '{"jalr",        7'b1100111, 3'd0, 1'b0, 0, 0, 3, 2'd0};
    tbl[12] = '{"jalr_bad_f3", 7'b1100111, 3'd1, 1'b0, 0, 0, 3, 2'd1};
    tbl[13] = '{"illegal",     7'b1111111, 3'd0, 1'b0, 0, 0, 3, 2'd1};
    tbl[14] = '{"fetch_tmo",   7'b0110011, 3'd0, 1'b0, 4, 0, 5, 2'd2};
    tbl[15] = '{"fetch_w3",    7'b0110011, 3'd0, 1'b0, 3, 0, 7, 2'd0};
    tbl[16] = '{"load_tmo",    7'b0000011, 3'd0, 1'b0, 0, 4, 8, 2'd2};
    tbl[17] = '{"store_w3",    7'b0100011, 3'd0, 1'b0, 0, 3, 7, 2'd0};

    legal[0] = 7'b0110011; legal[1] = 7'b0010011; legal[2] = 7'b0110111;
    legal[3] = 7'b0010111; legal[4] = 7'b0000011; legal[5] = 7'b0100011;
    legal[6] = 7'b1100011; legal[7] = 7'b1101111; legal[8] = 7'b1100111;
    legal[9] = 7'b1100111;

    do_reset();
    for (int i = 0; i < 18; i++) play(tbl[i]);

    // Asynchronous reset while a data read is outstanding.
    @(negedge clk); opcode = 7'b0000011; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    o = blank(4'd6); o.mem_req = 1'b1; o.iord = 1'b1;
    check("memrd_pending", sample(), o);
    #2 rst = 1'b0;
    #1 check("async_reset_now", sample(), '0);
    repeat (3) begin
      @(negedge clk);
      #1 check("async_reset_hold", sample(), '0);
    end
    @(negedge clk); rst = 1'b1;
    #1 check("async_release", sample(), '0);
    @(negedge clk);
    #1;
    o = blank(4'd1); o.mem_req = 1'b1;
    check("fetch_after_reset", sample(), o);
    do_reset();

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 11);
      v.opc = (r < 10) ? legal[r] : 7'($urandom_range(0, 127));
      v.f3 = (r == 9) ? 3'd0 : 3'($urandom_range(0, 7));
      v.taken = 1'($urandom_range(0, 1));
      v.fwait = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
      v.dwait = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
      v.cycles = 0;
      v.cause = 2'd0;
      v.name = $sformatf("rnd%0d", n);
      play(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
